alu_serial_sequencer: RTL and testbench

//   Bit-serial driver and collector for the 1-bit ALU function slice.

---
 rtl/alu_serial_sequencer.sv | 127 ++++++++++++
 tb/tb_alu_serial_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_serial_sequencer.sv
// Bit-serial sequencer for a 1-bit ALU slice: feeds operands LSB first,
// chains the slice carry and assembles the WIDTH-bit result.
module alu_serial_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic [3:0]       mux_sel,
    input  logic [1:0]       mc_sel,
    input  logic             cin0,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             sl_a,
    output logic             sl_b,
    output logic             sl_cin,
    output logic [3:0]       sl_mux,
    output logic [1:0]       sl_mc,
    input  logic             sl_out,
    input  logic             sl_cout,
    output logic [1:0]       state_dbg
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        DONE_ST = 2'd2
    } state_t;

    // Handshake: start is a level request, accepted only on an edge where
    // the sequencer is IDLE; done pulses one cycle when result/cout update.

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic             last_bit;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] opa_sh;
    logic [WIDTH-1:0] opb_sh;
    logic [WIDTH-1:0] shift_r;
    logic [WIDTH-1:0] result_r;
    logic             cout_r;
    logic             carry_r;
    logic [3:0]       mux_r;
    logic [1:0]       mc_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last_bit   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (cnt == LAST) begin
                    last_bit   = 1'b1;
                    state_next = DONE_ST;
                end
            end
            DONE_ST: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operands shift right so bit 0 of each shifter is always the current bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            opa_sh   <= '0;
            opb_sh   <= '0;
            shift_r  <= '0;
            result_r <= '0;
            cout_r   <= 1'b0;
            carry_r  <= 1'b0;
            mux_r    <= '0;
            mc_r     <= '0;
        end else if (accept) begin
            cnt     <= '0;
            opa_sh  <= opa;
            opb_sh  <= opb;
            mux_r   <= mux_sel;
            mc_r    <= mc_sel;
            carry_r <= cin0;
        end else if (state == RUN) begin
            cnt     <= cnt + CW'(1);
            opa_sh  <= opa_sh >> 1;
            opb_sh  <= opb_sh >> 1;
            carry_r <= sl_cout;
            shift_r <= {sl_out, shift_r[WIDTH-1:1]};
            if (last_bit) begin
                result_r <= {sl_out, shift_r[WIDTH-1:1]};
                cout_r   <= sl_cout;
            end
        end
    end

    assign busy      = (state == RUN) || (state == DONE_ST);
    assign done      = (state == DONE_ST);
    assign result    = result_r;
    assign cout      = cout_r;
    assign sl_a      = (state == RUN) && opa_sh[0];
    assign sl_b      = (state == RUN) && opb_sh[0];
    assign sl_cin    = (state == RUN) && carry_r;
    assign sl_mux    = mux_r;
    assign sl_mc     = mc_r;
    assign state_dbg = state;

endmodule

// File: tb/tb_alu_serial_sequencer.sv
// Directed + random bench for alu_serial_sequencer with a behavioural slice
// model and a scoreboard of {cout, result} expectations.
module tb_alu_serial_sequencer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] opa;
    logic [W-1:0] opb;
    logic [3:0]   mux_sel;
    logic [1:0]   mc_sel;
    logic         cin0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         sl_a;
    logic         sl_b;
    logic         sl_cin;
    logic [3:0]   sl_mux;
    logic [1:0]   sl_mc;
    logic         sl_out;
    logic         sl_cout;
    logic [1:0]   state_dbg;

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;
    logic prev_done = 1'b0;
    logic [W:0] exp_q[$];

    alu_serial_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .opa(opa), .opb(opb),
        .mux_sel(mux_sel), .mc_sel(mc_sel), .cin0(cin0), .busy(busy),
        .done(done), .result(result), .cout(cout), .sl_a(sl_a), .sl_b(sl_b),
        .sl_cin(sl_cin), .sl_mux(sl_mux), .sl_mc(sl_mc), .sl_out(sl_out),
        .sl_cout(sl_cout), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // Slice model: mc[1]=0 arithmetic (mux 6 subtracts), mc[1]=1 logic with cout=0.
    logic bb;
    always_comb begin
        bb      = (sl_mux == 4'h6) ? ~sl_b : sl_b;
        sl_out  = 1'b0;
        sl_cout = 1'b0;
        if (!sl_mc[1]) begin
            sl_out  = sl_a ^ bb ^ sl_cin;
            sl_cout = (sl_a & bb) | (sl_a & sl_cin) | (bb & sl_cin);
        end else begin
            case (sl_mux)
                4'h1:    sl_out = sl_a & sl_b;
                4'h0:    sl_out = ~sl_a;
                4'hE:    sl_out = sl_a | sl_b;
                4'h6:    sl_out = sl_a ^ sl_b;
                default: sl_out = sl_a;
            endcase
        end
    end

    function automatic logic [W:0] ref_op(logic [W-1:0] a, logic [W-1:0] b,
                                          logic [3:0] mux, logic [1:0] mc, logic ci);
        logic [W-1:0] beff;
        if (!mc[1]) begin
            beff = (mux == 4'h6) ? ~b : b;
            return {1'b0, a} + {1'b0, beff} + {{W{1'b0}}, ci};
        end
        case (mux)
            4'h1:    return {1'b0, a & b};
            4'h0:    return {1'b0, ~a};
            4'hE:    return {1'b0, a | b};
            4'h6:    return {1'b0, a ^ b};
            default: return {1'b0, a};
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every done pulse pops one expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            done_cnt++;
            check("done_single_pulse", 64'(prev_done), 64'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                check("result_cout", 64'({cout, result}), 64'(exp_q.pop_front()));
            end
        end
        prev_done = rst_n && done;
    end

    task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [3:0] mux, input logic [1:0] mc, input logic ci);
        @(negedge clk);
        opa = a; opb = b; mux_sel = mux; mc_sel = mc; cin0 = ci; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int lat);
        lat = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check(tag, 64'(done), 64'd1);
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [3:0] mux, input logic [1:0] mc, input logic ci,
                          input logic [W:0] exp);
        int lat;
        exp_q.push_back(exp);
        drive_start(a, b, mux, mc, ci);
        check({tag, "_first_bit"}, 64'({sl_a, sl_b, sl_cin, sl_mux, sl_mc, busy}),
              64'({a[0], b[0], ci, mux, mc, 1'b1}));
        wait_done({tag, "_done_seen"}, lat);
        check({tag, "_latency"}, 64'(lat), 64'(W + 1));
        @(negedge clk);
        check({tag, "_idle_after"}, 64'({busy, done, sl_a, sl_b, sl_cin}), 64'd0);
    endtask

    logic [3:0] mux_tab[6] = '{4'hF, 4'h6, 4'h1, 4'h0, 4'hE, 4'h6};
    logic [1:0] mc_tab[6]  = '{2'b00, 2'b00, 2'b11, 2'b10, 2'b10, 2'b11};

    initial begin
        int lat;
        int base;
        int t0;
        int d_times[$];
        int busy_low;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic rc;

        rst_n = 1'b0; start = 1'b0; opa = '0; opb = '0;
        mux_sel = '0; mc_sel = '0; cin0 = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              64'({busy, done, result, cout, sl_a, sl_b, sl_cin, sl_mux, sl_mc, state_dbg}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("add_5a_3c", 8'h5A, 8'h3C, 4'hF, 2'b00, 1'b0, {1'b0, 8'h96});
        run_op("add_ff_01", 8'hFF, 8'h01, 4'hF, 2'b00, 1'b0, {1'b1, 8'h00});
        run_op("add_ff_01_cin", 8'hFF, 8'h01, 4'hF, 2'b00, 1'b1, {1'b1, 8'h01});
        run_op("and_f0_3c", 8'hF0, 8'h3C, 4'h1, 2'b11, 1'b0, {1'b0, 8'h30});
        run_op("not_a5", 8'hA5, 8'h00, 4'h0, 2'b10, 1'b1, {1'b0, 8'h5A});
        check("result_held_idle", 64'({cout, result}), 64'({1'b0, 8'h5A}));

        for (int k = 0; k < 6; k++) begin
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            run_op("random_op", ra, rb, mux_tab[k], mc_tab[k], rc,
                   ref_op(ra, rb, mux_tab[k], mc_tab[k], rc));
        end

        // Second start two cycles into an operation must be ignored.
        base = done_cnt;
        exp_q.push_back({1'b0, 8'h96});
        drive_start(8'h5A, 8'h3C, 4'hF, 2'b00, 1'b0);
        @(negedge clk);
        opa = 8'h00; opb = 8'hFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("midop_operand_stable", 64'(sl_mux), 64'hF);
        wait_done("ignored_start_done", lat);
        repeat (15) @(negedge clk);
        check("ignored_start_one_done", 64'(done_cnt - base), 64'd1);

        // Reset with counter at 3 aborts silently.
        base = done_cnt;
        drive_start(8'h77, 8'h11, 4'hE, 2'b10, 1'b1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_outputs_zero",
              64'({busy, done, result, cout, sl_a, sl_b, sl_cin, sl_mux, sl_mc, state_dbg}), 64'd0);
        repeat (12) @(negedge clk);
        check("abort_no_done", 64'(done_cnt - base), 64'd0);
        rst_n = 1'b1;
        run_op("after_abort", 8'h0F, 8'hF1, 4'hF, 2'b00, 1'b0, {1'b1, 8'h00});

        // Back-to-back with start held high.
        repeat (3) exp_q.push_back({1'b0, 8'h46});
        @(negedge clk);
        opa = 8'h12; opb = 8'h34; mux_sel = 4'hF; mc_sel = 2'b00; cin0 = 1'b0; start = 1'b1;
        t0 = 0;
        busy_low = 0;
        while (d_times.size() < 3 && t0 < 60) begin
            @(negedge clk);
            t0++;
            if (done) d_times.push_back(t0);
            if (d_times.size() >= 1 && d_times.size() < 3 && !busy) busy_low++;
        end
        start = 1'b0;
        check("stream_three_dones", 64'(d_times.size()), 64'd3);
        if (d_times.size() == 3) begin
            check("stream_first_latency", 64'(d_times[0]), 64'(W + 1));
            check("stream_gap_1", 64'(d_times[1] - d_times[0]), 64'(W + 2));
            check("stream_gap_2", 64'(d_times[2] - d_times[1]), 64'(W + 2));
        end
        check("stream_busy_low_cycles", 64'(busy_low), 64'd2);
        repeat (15) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
